// File: rtl/ibex_pinmem_pkg.sv
// ibex_pinmem: shared types for the byte-wide pin memory link.
// States, port owners and the word/beat ratio.
package ibex_pinmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } pinmem_state_e;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } pinmem_owner_e;

  localparam int BeatsPerWord = 4;

endpackage

// File: rtl/ibex_pinmem_rr_arb.sv
// ibex_pinmem_rr_arb: two-way round-robin grant.
// Bit 0 is INSTR, bit 1 is DATA; last owner resets to DATA.
module ibex_pinmem_rr_arb
  import ibex_pinmem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  pinmem_owner_e last_q;
  pinmem_owner_e last_d;

  // Prefer the port that did not win last time.
  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (accept) begin
      gnt[0] = req[0] & (~req[1] | (last_q == DATA));
      gnt[1] = req[1] & (~req[0] | (last_q == INSTR));
      if (gnt[0]) last_d = INSTR;
      if (gnt[1]) last_d = DATA;
    end
  end

  // Remember the winner of each accepted grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= DATA;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/ibex_pinmem_ctrl.sv
// ibex_pinmem_ctrl: serialises Ibex instr/data words into byte beats.
// Optional per-beat stall timeout: define IBEX_PINMEM_TIMEOUT_EN.
module ibex_pinmem_ctrl
  import ibex_pinmem_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 255,
  parameter int unsigned TimeoutW      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        ext_valid_o,
  input  logic        ext_ready_i,
  output logic        ext_we_o,
  output logic        ext_be_o,
  output logic [1:0]  ext_beat_o,
  output logic [31:0] ext_addr_o,
  output logic [7:0]  ext_wdata_o,
  input  logic [7:0]  ext_rdata_i
);

  pinmem_state_e state_q;
  pinmem_owner_e owner_q;
  logic [29:0]   addr_q;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   asm_q;
  logic [1:0]    cnt_q;
  logic          err_q;
  logic [1:0]    gnt;

`ifdef IBEX_PINMEM_TIMEOUT_EN
  logic [TimeoutW-1:0] to_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TimeoutCycles, TimeoutW};
`endif

  logic unused_addr;
  assign unused_addr = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  ibex_pinmem_rr_arb u_arb (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .req    ({data_req_i, instr_req_i}),
    .accept (state_q == IDLE),
    .gnt    (gnt)
  );

  assign instr_gnt_o    = gnt[0];
  assign data_gnt_o     = gnt[1];
  assign instr_rvalid_o = (state_q == RESP) & (owner_q == INSTR);
  assign data_rvalid_o  = (state_q == RESP) & (owner_q == DATA);
  assign instr_rdata_o  = asm_q;
  assign data_rdata_o   = asm_q;

`ifdef IBEX_PINMEM_TIMEOUT_EN
  assign instr_err_o = instr_rvalid_o & err_q;
  assign data_err_o  = data_rvalid_o & err_q;
`else
  assign instr_err_o = 1'b0;
  assign data_err_o  = 1'b0;
`endif

  assign ext_valid_o = (state_q == BEAT);
  assign ext_we_o    = we_q;
  assign ext_be_o    = be_q[cnt_q];
  assign ext_beat_o  = cnt_q;
  assign ext_addr_o  = {addr_q, 2'b00};
  assign ext_wdata_o = wdata_q[{cnt_q, 3'b000} +: 8];

  // Grant latch, beat sequencing, word assembly and response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= INSTR;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= '0;
      asm_q   <= '0;
      cnt_q   <= 2'd0;
      err_q   <= 1'b0;
`ifdef IBEX_PINMEM_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt[1]) begin
            owner_q <= DATA;
            addr_q  <= data_addr_i[31:2];
            we_q    <= data_we_i;
            be_q    <= data_we_i ? data_be_i : 4'hF;
            wdata_q <= data_wdata_i;
          end else if (gnt[0]) begin
            owner_q <= INSTR;
            addr_q  <= instr_addr_i[31:2];
            we_q    <= 1'b0;
            be_q    <= 4'hF;
            wdata_q <= '0;
          end
          if (|gnt) begin
            cnt_q   <= 2'd0;
            asm_q   <= '0;
            err_q   <= 1'b0;
            state_q <= BEAT;
`ifdef IBEX_PINMEM_TIMEOUT_EN
            to_q    <= '0;
`endif
          end
        end
        BEAT: begin
          if (ext_ready_i) begin
            if (!we_q) asm_q[{cnt_q, 3'b000} +: 8] <= ext_rdata_i;
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'(BeatsPerWord - 1)) state_q <= RESP;
`ifdef IBEX_PINMEM_TIMEOUT_EN
            to_q <= '0;
          end else if (to_q == TimeoutW'(TimeoutCycles - 1)) begin
            err_q   <= 1'b1;
            asm_q   <= '0;
            state_q <= RESP;
          end else begin
            to_q <= to_q + 1'b1;
`endif
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ibex_pinmem_ctrl.sv
// tb_ibex_pinmem_ctrl: directed steps with a response/beat scoreboard.
// Build with IBEX_PINMEM_TIMEOUT_EN to exercise the timeout path.
module tb_ibex_pinmem_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_i = 1'b0;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_addr_i = '0;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        ext_valid_o;
  logic        ext_ready_i;
  logic        ext_we_o;
  logic        ext_be_o;
  logic [1:0]  ext_beat_o;
  logic [31:0] ext_addr_o;
  logic [7:0]  ext_wdata_o;
  logic [7:0]  ext_rdata_i;

  ibex_pinmem_ctrl #(.TimeoutCycles(4), .TimeoutW(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_addr_i(instr_addr_i),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .data_err_o(data_err_o),
    .ext_valid_o(ext_valid_o), .ext_ready_i(ext_ready_i),
    .ext_we_o(ext_we_o), .ext_be_o(ext_be_o),
    .ext_beat_o(ext_beat_o), .ext_addr_o(ext_addr_o),
    .ext_wdata_o(ext_wdata_o), .ext_rdata_i(ext_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int npass = 0;
  int ntot  = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    if (a == 32'h80) return 32'h13;
    return {a[15:0] ^ 16'h5A3C, a[31:16]};
  endfunction

  logic [31:0] mw;
  assign mw = model_word(ext_addr_o);
  assign ext_rdata_i = mw[{ext_beat_o, 3'b000} +: 8];

  bit hold_low = 1'b0;
  int stall_beat = 0;
  int stall_left = 0;
  logic stall_now;
  assign stall_now = ext_valid_o && (32'(ext_beat_o) == stall_beat)
                     && (stall_left > 0);
  assign ext_ready_i = !hold_low && !stall_now;
  always @(posedge clk_i) if (stall_now) stall_left <= stall_left - 1;

  typedef struct {
    bit port; logic [31:0] rdata; bit chk_data; bit err; int cyc;
  } resp_t;
  typedef struct {
    logic [31:0] addr; bit we; bit be; logic [1:0] beat; logic [7:0] wd;
  } beat_t;
  resp_t rq[$];
  beat_t bq[$];
  int resp_seen = 0;
  bit err_seen = 1'b0;

  task automatic push_expect(input bit port, input logic [31:0] a,
                             input bit we, input logic [3:0] be,
                             input logic [31:0] wd, input int ecyc);
    logic [31:0] aa;
    resp_t r;
    aa = a & 32'hFFFF_FFFC;
    for (int b = 0; b < 4; b++) begin
      beat_t e;
      e.addr = aa; e.we = we; e.beat = 2'(b);
      e.be = we ? be[b] : 1'b1;
      e.wd = we ? wd[8*b +: 8] : 8'h00;
      bq.push_back(e);
    end
    r.port = port; r.rdata = model_word(aa); r.chk_data = !we;
    r.err = 1'b0; r.cyc = ecyc;
    rq.push_back(r);
  endtask

  // Response and beat monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (instr_err_o || data_err_o) err_seen = 1'b1;
      if (instr_rvalid_o || data_rvalid_o) begin
        resp_seen++;
        if (rq.size() == 0) check("unexpected_rvalid", 1, 0);
        else begin
          resp_t r;
          r = rq.pop_front();
          check("rvalid_port", {instr_rvalid_o, data_rvalid_o},
                r.port ? 2'b01 : 2'b10);
          if (r.chk_data)
            check("rdata", r.port ? data_rdata_o : instr_rdata_o, r.rdata);
          check("err", r.port ? data_err_o : instr_err_o, r.err);
          if (r.cyc >= 0) check("rvalid_cycle", cyc, r.cyc);
        end
      end
      if (ext_valid_o && ext_ready_i) begin
        if (bq.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          beat_t e;
          e = bq.pop_front();
          check("beat", {ext_addr_o, ext_we_o, ext_be_o, ext_beat_o,
                         ext_we_o ? ext_wdata_o : 8'h00},
                {e.addr, e.we, e.be, e.beat, e.wd});
        end
      end
    end
  end

  task automatic do_req(input bit port, input logic [31:0] a, input bit we,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int stalls, output int gcyc);
    int n;
    @(posedge clk_i); #1;
    if (port) begin
      data_req_i = 1'b1; data_addr_i = a; data_we_i = we;
      data_be_i = be; data_wdata_i = wd;
    end else begin
      instr_req_i = 1'b1; instr_addr_i = a;
    end
    n = 0;
    do begin
      @(negedge clk_i); n++;
    end while (!(port ? data_gnt_o : instr_gnt_o) && n < 64);
    check("gnt_wait", 32'(n), 32'd1);
    gcyc = cyc;
    push_expect(port, a, we, be, wd, stalls < 0 ? -1 : cyc + 5 + stalls);
    @(posedge clk_i); #1;
    instr_req_i = 1'b0; data_req_i = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (rq.size() != 0 && n < limit) begin
      @(negedge clk_i); n++;
    end
    check("drain", 32'(rq.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1; rst_i = 1'b0;
    rq.delete(); bq.delete();
  endtask

  task automatic dual(input int ngr);
    int k, prev, n;
    k = 0; n = 0; prev = 0;
    @(posedge clk_i); #1;
    instr_req_i = 1'b1; instr_addr_i = 32'h300;
    data_req_i = 1'b1; data_addr_i = 32'h400;
    data_we_i = 1'b0; data_be_i = 4'hF;
    while (k < ngr && n < 100) begin
      @(negedge clk_i); n++;
      if (instr_gnt_o || data_gnt_o) begin
        bit own;
        own = data_gnt_o;
        check("gnt_onehot", instr_gnt_o & data_gnt_o, 0);
        check($sformatf("rr_grant%0d", k), own, k % 2);
        if (k > 0) check("rr_gap", 32'(cyc - prev), 6);
        prev = cyc;
        push_expect(own, own ? 32'h400 : 32'h300, 1'b0, 4'hF, 0, cyc + 5);
        k++;
      end
    end
    check("rr_done", 32'(k), 32'(ngr));
    @(posedge clk_i); #1;
    instr_req_i = 1'b0; data_req_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n, rs;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ctl", {instr_gnt_o, instr_rvalid_o, instr_err_o,
                      data_gnt_o, data_rvalid_o, data_err_o,
                      ext_valid_o, ext_we_o, ext_be_o, ext_beat_o}, 0);
    check("rst_rdata", {instr_rdata_o, data_rdata_o}, 0);
    check("rst_ext", {ext_addr_o, ext_wdata_o}, 0);
    @(posedge clk_i); #1; rst_i = 1'b0;

    do_req(1'b0, 32'h80, 1'b0, 4'hF, 0, 0, g);
    drain(20);

    stall_beat = 1; stall_left = 2;
    do_req(1'b1, 32'h1000, 1'b1, 4'h5, 32'hDEADBEEF, 2, g);
    drain(20);

    do_req(1'b1, 32'h1234_5677, 1'b0, 4'h3, 32'hFFFF_FFFF, 0, g);
    drain(20);

    do_req(1'b1, 32'h2002, 1'b1, 4'hA, 32'h0123_4567, 0, g);
    drain(20);

    do_reset();
    dual(3);
    drain(40);

    do_req(1'b0, 32'h200, 1'b0, 4'hF, 0, 0, g);
    n = 0;
    while (!(ext_valid_o && ext_beat_o == 2'd2) && n < 20) begin
      @(negedge clk_i); n++;
    end
    check("reach_beat2", {ext_valid_o, ext_beat_o}, 3'b110);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check("mid_rst_ctl", {instr_gnt_o, instr_rvalid_o, instr_err_o,
                          data_gnt_o, data_rvalid_o, data_err_o,
                          ext_valid_o, ext_we_o, ext_be_o, ext_beat_o}, 0);
    check("mid_rst_rdata", {instr_rdata_o, data_rdata_o}, 0);
    check("mid_rst_ext", {ext_addr_o, ext_wdata_o}, 0);
    rq.delete(); bq.delete();
    rs = resp_seen;
    @(posedge clk_i); #1; rst_i = 1'b0;
    repeat (6) @(negedge clk_i);
    check("no_resp_after_abort", 32'(resp_seen - rs), 0);
    dual(1);
    drain(20);

    hold_low = 1'b1;
    rs = resp_seen;
    err_seen = 1'b0;
`ifdef IBEX_PINMEM_TIMEOUT_EN
    do_req(1'b0, 32'h500, 1'b0, 4'hF, 0, 0, g);
    rq[0].err = 1'b1;
    rq[0].rdata = 32'h0;
    drain(20);
    check("timeout_resp", 32'(resp_seen - rs), 1);
    check("timeout_err_seen", err_seen, 1);
    bq.delete();
    hold_low = 1'b0;
    do_req(1'b0, 32'h600, 1'b0, 4'hF, 0, 0, g);
    drain(20);
`else
    do_req(1'b0, 32'h500, 1'b0, 4'hF, 0, -1, g);
    repeat (1000) @(negedge clk_i);
    check("hang_no_resp", 32'(resp_seen - rs), 0);
    check("hang_no_err", err_seen, 0);
    check("hang_valid_held", {ext_valid_o, ext_beat_o}, 3'b100);
    hold_low = 1'b0;
    drain(20);
    check("hang_released", 32'(resp_seen - rs), 1);
    check("hang_err_final", err_seen, 0);
`endif
    check("beats_consumed", 32'(bq.size()), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/ibex_pinmem_ctrl.md
# ibex_pinmem_ctrl

Sequences and arbitrates the Ibex instruction and data memory ports onto a single byte-wide, pad-limited external memory link. Each 32-bit access is granted to one port, serialised into four byte beats with a valid/ready handshake, and reassembled into a word response. The block sits between `ibex_top` and the chip pads. It replaces the per-port 8-bit read-data tie-off with real word transfers.

## Interface
Parameters:
- `TimeoutCycles`, 255: stall-cycle limit per beat; used only with the timeout feature.
- `TimeoutW`, 8: width of the timeout counter; must satisfy `TimeoutCycles < 2**TimeoutW`.

Ports (clock and reset first):
- `clk_i` in 1: single clock.
- `rst_i` in 1: **synchronous, active-high** reset.
- `instr_req_i` in 1: instruction request.
- `instr_gnt_o` out 1: instruction grant.
- `instr_rvalid_o` out 1: instruction response valid.
- `instr_addr_i` in 32: instruction address.
- `instr_rdata_o` out 32: instruction read word.
- `instr_err_o` out 1: instruction error.
- `data_req_i` in 1: data request.
- `data_gnt_o` out 1: data grant.
- `data_rvalid_o` out 1: data response valid.
- `data_we_i` in 1: data write enable.
- `data_be_i` in 4: data byte enables.
- `data_addr_i` in 32: data address.
- `data_wdata_i` in 32: data write word.
- `data_rdata_o` out 32: data read word.
- `data_err_o` out 1: data error.
- `ext_valid_o` out 1: beat valid.
- `ext_ready_i` in 1: beat accepted.
- `ext_we_o` out 1: beat is a write.
- `ext_be_o` out 1: this byte is enabled; always 1 for reads.
- `ext_beat_o` out 2: byte index, 0 to 3.
- `ext_addr_o` out 32: word address `{addr[31:2],2'b00}`.
- `ext_wdata_o` out 8: write byte.
- `ext_rdata_i` in 8: read byte, sampled on the handshake.

## Operation
States: IDLE, BEAT, RESP.

IDLE
- `*_gnt_o` is a combinational pulse for the port selected while in IDLE and at least one `*_req_i` is high.
- On grant, the block latches the owner, addr, we, be and wdata. The instruction port always has `we=0` and `be=4'hF`.
- It then clears the beat counter and the assembly register, and moves to BEAT.

Arbitration (round robin)
- If both ports request, the port that was not the last owner wins.
- The last-owner flag resets to DATA, so the first simultaneous request goes to INSTR.
- A single requester always wins.

BEAT
- `ext_valid_o` is 1 throughout; beats are little-endian, byte n first.
- `ext_wdata_o = wdata[8n+7:8n]` and `ext_be_o = be[n]`.
- Masked bytes are still transferred as beats.
- On `ext_valid_o && ext_ready_i`:
  - For reads, `ext_rdata_i` is stored into byte n.
  - The beat counter increments.
  - After beat 3 completes, the block moves to RESP.
- `ext_valid_o` and the payload are held stable until ready; a beat is never withdrawn.

RESP
- The owner's `*_rvalid_o` is 1 for exactly one cycle, then the block returns to IDLE.
- `*_rdata_o` equals the assembled word while rvalid is high; for writes it carries the same assembled value (don't-care data).

Other rules
- A requester that is not granted is held; the block never drops a pending request silently.
- Reset at any point, including mid-beat, returns to IDLE with the counter cleared, the assembly register zeroed and last-owner set to DATA. No response is issued for the aborted access.

Reset values
- All outputs are 0, except `ext_addr_o`, which is 0 because it comes from the cleared latch.

## Timing
- Grant is in cycle N (IDLE).
- With `ext_ready_i` tied high, beats occur in cycles N+1 to N+4 and rvalid in cycle N+5.
- The next grant is possible no earlier than N+6.
- Each cycle of `ext_ready_i=0` adds one cycle of latency.
- No combinational path runs from `ext_*` inputs to `*_gnt_o`. Grant depends only on state, the `*_req_i` inputs and the last-owner flag.

## Configuration
Macro: `IBEX_PINMEM_TIMEOUT_EN`.

Defined
- A counter runs during BEAT while `ext_ready_i=0` and clears on every handshake.
- When it reaches `TimeoutCycles`, the block aborts and goes to RESP.
- In RESP it asserts the owner's `*_err_o` together with `*_rvalid_o` for one cycle, with rdata = 0.

Undefined
- The counter is absent.
- `*_err_o` is tied to 0.
- BEAT waits indefinitely.

## Structure
- Package `ibex_pinmem_pkg` holds:
  - the `pinmem_state_e` enum (IDLE, BEAT, RESP);
  - the `pinmem_owner_e` enum (INSTR, DATA);
  - `BeatsPerWord = 4`.
- Sub-module `ibex_pinmem_rr_arb` contains the 2-requester round-robin grant with the last-owner register. It has inputs `req[1:0]` and `accept`, and output `gnt[1:0]`.

## Test plan
- **Single instruction read:** instr read at addr 0x80, ext bytes 0x13,0x00,0x00,0x00, ready high → grant at N, `ext_addr_o=0x80`, `instr_rvalid_o` at N+5 with rdata 0x00000013.
- **Data write with stalls:** data write, wdata 0xDEADBEEF, be 0x5, ready low 2 cycles on beat 1 → bytes EF,BE,AD,DE with ext_be 1,0,1,0; rvalid at N+7.
- **Simultaneous requests:** both requesting continuously after reset → grants alternate INSTR, DATA, INSTR; neither port ever wins twice in a row.
- **Mid-beat reset:** `rst_i` asserted during beat 2 → next cycle IDLE, all outputs 0, no rvalid; the next grant goes to INSTR.
- **Timeout (macro defined, TimeoutCycles=4):** `ext_ready_i` held low in beat 0 → rvalid with `*_err_o=1` and rdata 0 after 4 stall cycles.
- **Timeout macro undefined:** same stimulus → no rvalid after 1000 cycles, `*_err_o` stays 0; releasing ready completes the access normally.
